// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared widths, the NOP encoding, the fetch packet layout and
//               the queue occupancy states used across the IF/ID boundary.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;

    // Presented to decode whenever the queue has nothing to offer.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

    // One fetched word together with the PC values that travel with it.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pc4;
    } fetch_pkt_t;

    // Queue state as seen through its occupancy.
    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_e;

endpackage
`default_nettype wire

// File: rtl/fq_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fq_ptr_ctrl
// Description : Read/write pointer and occupancy bookkeeping for the fetch
//               queue, with full/empty flags derived from registered state.
// Revision    : 1.0 - initial release
// ============================================================================
module fq_ptr_ctrl
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [$clog2(DEPTH)-1:0]   o_rdPtr,
    output logic [$clog2(DEPTH)-1:0]   o_wrPtr,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam int                 c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEPTH);

    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] w_rdPtrNxt;
    logic [c_PTR_W-1:0] w_wrPtrNxt;
    logic [c_CNT_W-1:0] w_countNxt;
    occ_e               w_occ;

    // Pointer and occupancy registers; storage itself is never reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            r_rdPtr <= w_rdPtrNxt;
            r_wrPtr <= w_wrPtrNxt;
            r_count <= w_countNxt;
        end
    end

    // Classify the current occupancy into EMPTY / PARTIAL / FULL.
    always_comb begin
        w_occ = OCC_PARTIAL;
        if (r_count == '0) begin
            w_occ = OCC_EMPTY;
        end else if (r_count == c_CNT_MAX) begin
            w_occ = OCC_FULL;
        end
    end

    // Next pointers/count; flush wins, pointers wrap naturally (DEPTH is 2^n).
    always_comb begin
        w_rdPtrNxt = r_rdPtr;
        w_wrPtrNxt = r_wrPtr;
        w_countNxt = r_count;
        if (i_flush) begin
            w_rdPtrNxt = '0;
            w_wrPtrNxt = '0;
            w_countNxt = '0;
        end else begin
            case (w_occ)
                OCC_EMPTY: begin
                    // Nothing to pop, and no bypass: the word lands in storage.
                    if (i_push) begin
                        w_wrPtrNxt = r_wrPtr + c_PTR_ONE;
                        w_countNxt = r_count + c_CNT_ONE;
                    end
                end
                OCC_PARTIAL: begin
                    if (i_push) begin
                        w_wrPtrNxt = r_wrPtr + c_PTR_ONE;
                    end
                    if (i_pop) begin
                        w_rdPtrNxt = r_rdPtr + c_PTR_ONE;
                    end
                    if (i_push && !i_pop) begin
                        w_countNxt = r_count + c_CNT_ONE;
                    end else if (i_pop && !i_push) begin
                        w_countNxt = r_count - c_CNT_ONE;
                    end
                end
                OCC_FULL: begin
                    // Push is already masked by the full flag upstream.
                    if (i_pop) begin
                        w_rdPtrNxt = r_rdPtr + c_PTR_ONE;
                        w_countNxt = r_count - c_CNT_ONE;
                    end
                end
                default: begin
                    w_countNxt = r_count;
                end
            endcase
        end
    end

    assign o_rdPtr = r_rdPtr;
    assign o_wrPtr = r_wrPtr;
    assign o_count = r_count;
    assign o_full  = (r_count == c_CNT_MAX);
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/fetch_decode_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode_queue
// Description : IF/ID instruction queue. Buffers {instr, pc, pc_plus4} from
//               fetch, rides out a decode stall, and drops wrong-path words
//               on flush. Decode sees the head one cycle after capture.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_valid,
    input  logic [INSTR_W-1:0]       fetch_instr,
    input  logic [ADDR_W-1:0]        fetch_pc,
    input  logic [ADDR_W-1:0]        fetch_pc4,
    output logic                     fetch_hold,
    input  logic                     dec_ready,
    output logic                     dec_valid,
    output logic [INSTR_W-1:0]       dec_instr,
    output logic [ADDR_W-1:0]        dec_pc,
    output logic [ADDR_W-1:0]        dec_pc4,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [c_PTR_W-1:0] w_rdPtr;
    logic [c_PTR_W-1:0] w_wrPtr;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    fetch_pkt_t         w_inPkt;
    fetch_pkt_t         w_head;
    fetch_pkt_t         r_storage [DEPTH];

    // Words arriving while full are dropped; flush kills both directions.
    assign w_push = fetch_valid & ~w_full & ~flush;
    assign w_pop  = dec_valid & dec_ready & ~flush;

    fq_ptr_ctrl #(
        .DEPTH   (DEPTH)
    ) u_ptrCtrl (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (flush),
        .o_rdPtr (w_rdPtr),
        .o_wrPtr (w_wrPtr),
        .o_count (count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_inPkt = '{instr: fetch_instr, pc: fetch_pc, pc4: fetch_pc4};

    // Capture the fetched word at the write pointer; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_storage[w_wrPtr] <= w_inPkt;
        end
    end

    assign w_head = r_storage[w_rdPtr];

    // Head is shown only when valid so stale or uninitialised storage never leaks.
    assign dec_valid  = ~w_empty;
    assign dec_instr  = dec_valid ? w_head.instr : NOP_INSTR;
    assign dec_pc     = dec_valid ? w_head.pc    : '0;
    assign dec_pc4    = dec_valid ? w_head.pc4   : '0;
    assign fetch_hold = w_full;

endmodule
`default_nettype wire
